// File: rtl/acc_trace_fifo.sv
// Accumulator trace capture: pushes each new accumulator value into a
// small first-word-fall-through FIFO, with sticky overflow and a saturating drop count.
module acc_trace_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] acc_in,
  input  logic          capture_en,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    drop_cnt
);

  logic [DW-1:0] acc_q_reg;
  logic          first_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;
  logic [7:0]    drop_cnt_reg;
  logic [DW-1:0] storage [DEPTH];

  logic change_event;
  logic pop;
  logic push;
  logic drop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign count = count_reg;
  assign dout  = storage[rd_ptr_reg];
  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;

  // A held value yields one event; the first enabled edge always captures.
  assign change_event = capture_en && (first_reg || (acc_in != acc_q_reg));
  assign pop  = rd_en && !empty;
  assign push = change_event && (!full || pop);
  assign drop = change_event && full && !pop;

  // Storage has no reset; a full-and-pop push overwrites the head being consumed.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      storage[wr_ptr_reg] <= acc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q_reg    <= '0;
      first_reg    <= 1'b1;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      acc_q_reg <= acc_in;
      if (capture_en) begin
        first_reg <= 1'b0;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != 8'hFF) begin
          drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_trace_fifo.sv
// Scenario-per-task bench for acc_trace_fifo; expected trace entries are queued
// as stimulus is driven and compared as the FIFO is drained.
module tb_acc_trace_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] acc_in;
  logic       capture_en;
  logic       rd_en;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;
  logic [7:0] drop_cnt;

  int checks;
  int errors;
  logic [7:0] exp_q[$];

  acc_trace_fifo #(.DW(8), .DEPTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .acc_in(acc_in),
    .capture_en(capture_en),
    .rd_en(rd_en),
    .dout(dout),
    .empty(empty),
    .full(full),
    .count(count),
    .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    capture_en = 1'b0;
    rd_en = 1'b0;
    acc_in = 8'h00;
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_first_hold();
    int n;
    capture_en = 1'b1;
    acc_in = 8'h00;
    exp_q.push_back(8'h00);
    for (int i = 0; i < 5; i++) tick();
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL hold_count: got %0d expected 1", count); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL hold_dout: got %02h expected 00", dout); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (empty !== 1'b0 || dout !== exp_q[0]) begin errors++; $display("FAIL hold_drain: got %02h empty=%0b expected %02h", dout, empty, exp_q[0]); end
      $display("pop %02h", dout);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      void'(exp_q.pop_front());
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL hold_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_sequence();
    logic [7:0] seq [5];
    int n;
    seq = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h33};
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    capture_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      acc_in = seq[i];
      tick();
    end
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL seq_count: got %0d expected 3", count); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (empty !== 1'b0 || dout !== exp_q[0]) begin errors++; $display("FAIL seq_drain: got %02h empty=%0b expected %02h", dout, empty, exp_q[0]); end
      $display("pop %02h", dout);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      void'(exp_q.pop_front());
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL seq_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    capture_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      acc_in = 8'(i);
      if (i <= 8) exp_q.push_back(8'(i));
      tick();
      checks++; if (drop_cnt !== ((i > 8) ? 8'(i - 8) : 8'd0)) begin errors++; $display("FAIL ovf_step_drop: got %0d at value %0d", drop_cnt, i); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %0b expected 1", full); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (empty !== 1'b0 || dout !== exp_q[0]) begin errors++; $display("FAIL ovf_drain: got %02h empty=%0b expected %02h", dout, empty, exp_q[0]); end
      $display("pop %02h", dout);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      void'(exp_q.pop_front());
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_full_pop();
    int n;
    do_reset();
    capture_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      acc_in = 8'hA0 + 8'(i);
      exp_q.push_back(acc_in);
      tick();
    end
    checks++; if (dout !== 8'hA0) begin errors++; $display("FAIL fp_head: got %02h expected a0", dout); end
    acc_in = 8'h5A;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h5A);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL fp_count: got %0d expected 8", count); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL fp_drop_cnt: got %0d expected 0", drop_cnt); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fp_full: got %0b expected 1", full); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (empty !== 1'b0 || dout !== exp_q[0]) begin errors++; $display("FAIL fp_drain: got %02h empty=%0b expected %02h", dout, empty, exp_q[0]); end
      $display("pop %02h", dout);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      void'(exp_q.pop_front());
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fp_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_saturate_reset();
    do_reset();
    capture_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      acc_in = 8'hB0 + 8'(i);
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      acc_in = (i % 2 == 0) ? 8'hC0 : 8'hC1;
      tick();
      if (i == 253) begin
        checks++; if (drop_cnt !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", drop_cnt); end
      end
      if (i == 254) begin
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", drop_cnt); end
      end
    end
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d expected 255", drop_cnt); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL sat_count: got %0d expected 8", count); end
    // Mid-stream reset with a push candidate and a pop request both present.
    reset = 1'b1; rd_en = 1'b1; acc_in = 8'hD5;
    tick();
    reset = 1'b0; capture_en = 1'b0;
    exp_q.delete();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %0b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL mid_full: got %0b expected 0", full); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %0b expected 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL mid_drop_cnt: got %0d expected 0", drop_cnt); end
    tick();
    rd_en = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL post_reset_pop: got %0d expected 0", count); end
  endtask

  task automatic test_enable_gap();
    int n;
    capture_en = 1'b1; acc_in = 8'h01; exp_q.push_back(8'h01);
    tick();
    capture_en = 1'b0; acc_in = 8'h02;
    tick();
    capture_en = 1'b1;
    tick();
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL gap_no_push: got %0d expected 1", count); end
    acc_in = 8'h03; exp_q.push_back(8'h03);
    tick();
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL gap_push: got %0d expected 2", count); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (empty !== 1'b0 || dout !== exp_q[0]) begin errors++; $display("FAIL gap_drain: got %02h empty=%0b expected %02h", dout, empty, exp_q[0]); end
      $display("pop %02h", dout);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      void'(exp_q.pop_front());
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL gap_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_empty_push_pop();
    acc_in = 8'h77; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL epp_count: got %0d expected 1", count); end
    checks++; if (empty !== 1'b0 || dout !== 8'h77) begin errors++; $display("FAIL epp_dout: got %02h empty=%0b expected 77", dout, empty); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    acc_in = 8'h00;
    capture_en = 1'b0;
    rd_en = 1'b0;
    test_reset();
    test_first_hold();
    test_sequence();
    test_overflow();
    test_full_pop();
    test_saturate_reset();
    test_enable_gap();
    test_empty_push_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
